// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Round-robin arbiter that shares one cke-enabled SPU op among NUM_PORTS requesters and routes results back by tag.
// Optional grant lock: define ELIXIRCHIP_ES1_SPU_OP_ARBITER_LOCK_EN.
module elixirchip_es1_spu_op_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int LATENCY   = 3,
  parameter int DATA_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cke,
  input  logic [NUM_PORTS-1:0]           s_valid,
  input  logic [NUM_PORTS*DATA_BITS-1:0] s_data,
  input  logic [NUM_PORTS-1:0]           s_clear,
  input  logic [NUM_PORTS-1:0]           s_lock,
  output logic [NUM_PORTS-1:0]           s_ready,
  output logic                           op_valid,
  output logic                           op_clear,
  output logic [DATA_BITS-1:0]           op_data,
  input  logic [DATA_BITS-1:0]           op_result,
  output logic [NUM_PORTS-1:0]           m_valid,
  output logic [DATA_BITS-1:0]           m_data
);

  localparam int           IDW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDW:0] NP        = (IDW+1)'(NUM_PORTS);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_PORTS - 1);

  logic [IDW-1:0]            last_grant;
  logic [IDW-1:0]            rr_id;
  logic                      rr_found;
  logic [IDW:0]              cand;
  logic [IDW-1:0]            grant_id;
  logic                      lock_win;
  logic                      accept;
  logic [LATENCY:0]          tag_valid;
  logic [LATENCY:0][IDW-1:0] tag_id;

  // Search starts just past the last grant; the sum stays below 2*NUM_PORTS so one subtraction wraps it.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(i);
      if (cand >= NP) cand = cand - NP;
      if (!rr_found && s_valid[cand[IDW-1:0]]) begin
        rr_found = 1'b1;
        rr_id    = cand[IDW-1:0];
      end
    end
  end

`ifdef ELIXIRCHIP_ES1_SPU_OP_ARBITER_LOCK_EN
  logic lock_hold;

  assign lock_win = lock_hold & s_valid[last_grant] & s_lock[last_grant];

  // Lock is released as soon as the holder drops s_lock or s_valid, even if nobody else is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_hold <= 1'b0;
    end else if (cke) begin
      if (accept)         lock_hold <= s_lock[grant_id];
      else if (!lock_win) lock_hold <= 1'b0;
    end
  end
`else
  logic unused_lock;

  assign lock_win    = 1'b0;
  assign unused_lock = ^s_lock;
`endif

  assign grant_id = lock_win ? last_grant : rr_id;

  always_comb begin
    s_ready = '0;
    if (cke && !reset && (lock_win || rr_found)) s_ready[grant_id] = 1'b1;
  end

  assign accept = |s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_INIT;
      op_valid   <= 1'b0;
      op_clear   <= 1'b0;
      op_data    <= '0;
    end else if (cke) begin
      op_valid <= accept;
      op_clear <= accept & s_clear[grant_id];
      if (accept) begin
        op_data    <= s_data[grant_id*DATA_BITS +: DATA_BITS];
        last_grant <= grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
    end else if (cke) begin
      tag_valid[0] <= accept;
      tag_id[0]    <= grant_id;
      for (int unsigned k = 1; k <= LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    m_valid = '0;
    if (tag_valid[LATENCY]) m_valid[tag_id[LATENCY]] = 1'b1;
  end

  assign m_data = op_result;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Self-checking bench for elixirchip_es1_spu_op_arbiter with a nop op (clear returns 123) attached.
module tb_elixirchip_es1_spu_op_arbiter;

  localparam int NP  = 4;
  localparam int LAT = 3;
  localparam int DB  = 8;
  localparam logic [DB-1:0] CLEAR_DATA = 8'd123;

  logic             clk = 1'b0;
  logic             reset, cke;
  logic [NP-1:0]    s_valid, s_clear, s_lock, s_ready, m_valid;
  logic [NP*DB-1:0] s_data;
  logic             op_valid, op_clear;
  logic [DB-1:0]    op_data, op_result, m_data;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_arbiter #(.NUM_PORTS(NP), .LATENCY(LAT), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .s_valid(s_valid), .s_data(s_data), .s_clear(s_clear), .s_lock(s_lock), .s_ready(s_ready),
    .op_valid(op_valid), .op_clear(op_clear), .op_data(op_data), .op_result(op_result),
    .m_valid(m_valid), .m_data(m_data)
  );

  // Attached nop op: LAT cke-enabled stages, clear substitutes the constant.
  logic [DB-1:0] op_pipe [0:LAT-1];
  always @(posedge clk) begin
    if (cke) begin
      op_pipe[0] <= op_clear ? CLEAR_DATA : op_data;
      for (int k = 1; k < LAT; k++) op_pipe[k] <= op_pipe[k-1];
    end
  end
  assign op_result = op_pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer, issue registers, and a queue of in-flight beats with edge countdowns.
  typedef struct { int port; logic [DB-1:0] data; int left; } beat_t;
  beat_t         q[$];
  int            m_lg;
  logic          e_ov, e_oc;
  logic [DB-1:0] e_od;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ARBITER_LOCK_EN
  bit            m_lock;
`endif

  int            grant_log[$];
  int            ret_port[$];
  int            ret_data[$];

  function automatic logic [NP-1:0] model_ready();
    logic [NP-1:0] r = '0;
    if (reset || !cke) return r;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ARBITER_LOCK_EN
    if (m_lock && s_valid[m_lg] && s_lock[m_lg]) begin
      r[m_lg] = 1'b1;
      return r;
    end
`endif
    for (int i = 1; i <= NP; i++) begin
      int p = (m_lg + i) % NP;
      if (s_valid[p]) begin
        r[p] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  logic [NP-1:0] er, em;
  logic [DB-1:0] ed;
  int            gp;

  always @(negedge clk) begin
    if (chk_en) begin
      er = model_ready();
      check("s_ready", s_ready, er);
      check("op_valid", op_valid, e_ov);
      check("op_clear", op_clear, e_oc);
      check("op_data", op_data, e_od);
      em = '0;
      ed = '0;
      if (q.size() > 0 && q[0].left == 0) begin
        em[q[0].port] = 1'b1;
        ed            = q[0].data;
      end
      check("m_valid", m_valid, em);
      if (em != 0) check("m_data", m_data, ed);

      for (int i = 0; i < NP; i++) if (s_ready[i]) grant_log.push_back(i);
      if (cke && !reset)
        for (int i = 0; i < NP; i++)
          if (m_valid[i]) begin
            ret_port.push_back(i);
            ret_data.push_back(int'(m_data));
          end

      gp = 0;
      for (int i = 0; i < NP; i++) if (er[i]) gp = i;
      if (reset) begin
        m_lg = NP - 1;
        e_ov = 1'b0;
        e_oc = 1'b0;
        e_od = '0;
        q.delete();
`ifdef ELIXIRCHIP_ES1_SPU_OP_ARBITER_LOCK_EN
        m_lock = 1'b0;
`endif
      end else if (cke) begin
        if (q.size() > 0 && q[0].left == 0) void'(q.pop_front());
        foreach (q[i]) q[i].left--;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ARBITER_LOCK_EN
        if (er != 0) m_lock = s_lock[gp];
        else if (!(s_valid[m_lg] && s_lock[m_lg])) m_lock = 1'b0;
`endif
        if (er != 0) begin
          beat_t b;
          b.port = gp;
          b.data = s_clear[gp] ? CLEAR_DATA : s_data[gp*DB +: DB];
          b.left = LAT;
          q.push_back(b);
          e_ov = 1'b1;
          e_oc = s_clear[gp];
          e_od = s_data[gp*DB +: DB];
          m_lg = gp;
        end else begin
          e_ov = 1'b0;
          e_oc = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    ret_port.delete();
    ret_data.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    cke     = 1'b1;
    s_valid = '1;
    s_data  = '0;
    s_clear = '0;
    s_lock  = '0;

    // Reset state
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", s_ready, 4'b0000);
    step();
    reset   = 1'b0;
    s_valid = '0;
    @(negedge clk);
    check("rst_op_valid", op_valid, 1'b0);
    check("rst_op_data", op_data, 8'h00);
    check("rst_m_valid", m_valid, 4'b0000);

    // Single beat on port 2
    step();
    s_valid = 4'b0100;
    s_data  = 32'h0055_0000;
    @(negedge clk);
    check("p2_ready", s_ready, 4'b0100);
    step();
    s_valid = '0;
    @(negedge clk);
    check("p2_op_valid", op_valid, 1'b1);
    check("p2_op_data", op_data, 8'h55);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("p2_m_valid", m_valid, 4'b0100);
    check("p2_m_data", m_data, 8'h55);

    // All ports streaming, with a two-cycle cke stall in the middle
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
    s_data = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int k = 0; k < 10; k++) begin
      step();
      s_valid = '1;
      cke     = (k != 4 && k != 5);
      if (k == 4) begin
        @(negedge clk);
        check("stall_ready", s_ready, 4'b0000);
      end
    end
    step();
    s_valid = '0;
    cke     = 1'b1;
    repeat (8) step();
    check("rr_ngrants", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) check("rr_grant", grant_log[i], i % 4);
    check("rr_nret", ret_port.size(), 8);
    for (int i = 0; i < ret_port.size(); i++) begin
      check("rr_ret_port", ret_port[i], i % 4);
      check("rr_ret_data", ret_data[i], i % 4);
    end

    // Clear beat on port 1
    clear_logs();
    s_valid = 4'b0010;
    s_clear = 4'b0010;
    s_data  = 32'h0000_1400;
    @(negedge clk);
    check("clr_ready", s_ready, 4'b0010);
    step();
    s_valid = '0;
    s_clear = '0;
    @(negedge clk);
    check("clr_op_clear", op_clear, 1'b1);
    check("clr_op_data", op_data, 8'd20);
    repeat (6) step();
    check("clr_nret", ret_port.size(), 1);
    if (ret_port.size() == 1) begin
      check("clr_ret_port", ret_port[0], 1);
      check("clr_ret_data", ret_data[0], 123);
    end

    // Reset with three beats in flight
    clear_logs();
    s_data  = {8'd3, 8'd2, 8'd1, 8'd0};
    s_valid = '1;
    step();
    step();
    step();
    s_valid = '0;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
    s_valid = '1;
    @(negedge clk);
    check("mid_rst_m_valid", m_valid, 4'b0000);
    check("mid_rst_op_valid", op_valid, 1'b0);
    check("mid_rst_ready", s_ready, 4'b0001);
    step();
    s_valid = '0;
    repeat (8) step();
    check("mid_rst_nret", ret_port.size(), 1);
    if (ret_port.size() == 1) check("mid_rst_ret_port", ret_port[0], 0);

    // Lock request from port 0 for three beats
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
    s_valid = 4'b0011;
    s_lock  = 4'b0001;
    step();
    step();
    step();
    s_lock = '0;
    step();
    s_valid = '0;
    repeat (6) step();
    check("lock_ngrants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
`ifdef ELIXIRCHIP_ES1_SPU_OP_ARBITER_LOCK_EN
      check("lock_g0", grant_log[0], 0);
      check("lock_g1", grant_log[1], 0);
      check("lock_g2", grant_log[2], 0);
      check("lock_g3", grant_log[3], 1);
`else
      check("lock_g0", grant_log[0], 0);
      check("lock_g1", grant_log[1], 1);
      check("lock_g2", grant_log[2], 0);
      check("lock_g3", grant_log[3], 1);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
